// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns in a..g
// order (index 0 is segment a), active-low, plus the blink phase type.
package seven_seg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0001100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  // Blink phase: lit digits show normally, dark digits are forced off
  typedef enum logic {
    BLINK_LIT  = 1'b0,
    BLINK_DARK = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern. Codes 10..15 show A,b,C,d,E,F
// only when HEX_MODE is nonzero; otherwise they are blanked.
module seg7_hex_decode
  import seven_seg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Pure lookup; decimal codes are always shown, hex letters are optional
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = (HEX_MODE != 0) ? SEG_A : SEG_BLANK;
      4'hB: seg_o = (HEX_MODE != 0) ? SEG_B : SEG_BLANK;
      4'hC: seg_o = (HEX_MODE != 0) ? SEG_C : SEG_BLANK;
      4'hD: seg_o = (HEX_MODE != 0) ? SEG_D : SEG_BLANK;
      4'hE: seg_o = (HEX_MODE != 0) ? SEG_E : SEG_BLANK;
      4'hF: seg_o = (HEX_MODE != 0) ? SEG_F : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner. Each digit owns a slot of
// SCAN_DIV cycles whose first cycle is anode dead time. Inputs are captured
// once per frame at the start of slot 0 so a frame never shows torn data.
// All outputs are registered: the output cycle after an edge reflects the
// slot position the prescaler held at that edge.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  output logic [0:6]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

  logic [CNT_W-1:0]      prescale_q, prescale_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blinkCnt_q, blinkCnt_d;
  blink_phase_e          blinkPhase_q, blinkPhase_d;
  logic [4*NUM_DIGITS-1:0] snapDigits_q;
  logic [NUM_DIGITS-1:0] snapDp_q, snapBlink_q;
  logic                  snapBlankLz_q;
  logic [0:6]            seg_q, seg_d;
  logic                  dpN_q, dpN_d;
  logic [NUM_DIGITS-1:0] anN_q, anN_d;
  logic                  frameTick_q;

  logic                    firstSlot, slotEnd, frameEnd;
  logic [4*NUM_DIGITS-1:0] effDigits;
  logic [NUM_DIGITS-1:0]   effDp, effBlink;
  logic                    effBlankLz;
  logic [3:0]              curNibble;
  logic                    curLz, curDp, curBlink, allZero, blinkedOff;
  logic [0:6]              segLit;

  // In the first cycle of a frame the live inputs are used directly, since
  // the snapshot registers only capture them at that same edge
  always_comb begin
    firstSlot  = (prescale_q == '0) && (idx_q == '0);
    slotEnd    = (prescale_q == CNT_LAST);
    frameEnd   = slotEnd && (idx_q == IDX_LAST);
    effDigits  = firstSlot ? digits   : snapDigits_q;
    effDp      = firstSlot ? dp_in    : snapDp_q;
    effBlink   = firstSlot ? blink_en : snapBlink_q;
    effBlankLz = firstSlot ? blank_lz : snapBlankLz_q;
  end

  // Slot timing and blink phase; the phase advances on the last cycle of a
  // frame so it is already settled when the next frame begins
  always_comb begin
    prescale_d   = slotEnd ? '0 : prescale_q + 1'b1;
    idx_d        = idx_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (slotEnd) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frameEnd) begin
      if (blinkCnt_q == BLK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = (blinkPhase_q == BLINK_LIT) ? BLINK_DARK : BLINK_LIT;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  // Walk from the most significant digit down so allZero tells whether the
  // selected digit and everything above it are zero
  always_comb begin
    allZero   = 1'b1;
    curNibble = 4'h0;
    curLz     = 1'b0;
    curDp     = 1'b0;
    curBlink  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allZero = allZero & (effDigits[i*4 +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) begin
        curNibble = effDigits[i*4 +: 4];
        curLz     = allZero && (i != 0);
        curDp     = effDp[i];
        curBlink  = effBlink[i];
      end
    end
  end

  seg7_hex_decode #(
    .HEX_MODE(HEX_MODE)
  ) uDecode (
    .nibble_i(curNibble),
    .seg_o   (segLit)
  );

  // Final per-slot pattern: blinking wins over everything, leading-zero
  // blanking only affects the segments, and the first slot cycle is dead time
  always_comb begin
    blinkedOff = curBlink && (blinkPhase_q == BLINK_DARK);
    seg_d      = (blinkedOff || (effBlankLz && curLz)) ? SEG_BLANK : segLit;
    dpN_d      = blinkedOff ? 1'b1 : ~curDp;
    anN_d      = (prescale_q == '0) ? '1 : ~(ANODE_ONE << idx_q);
  end

  // State and registered outputs; while disabled everything holds except
  // the anodes, which are switched off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q    <= '0;
      idx_q         <= '0;
      blinkCnt_q    <= '0;
      blinkPhase_q  <= BLINK_LIT;
      snapDigits_q  <= '0;
      snapDp_q      <= '0;
      snapBlink_q   <= '0;
      snapBlankLz_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      dpN_q         <= 1'b1;
      anN_q         <= '1;
      frameTick_q   <= 1'b0;
    end else if (enable) begin
      prescale_q   <= prescale_d;
      idx_q        <= idx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      if (firstSlot) begin
        snapDigits_q  <= digits;
        snapDp_q      <= dp_in;
        snapBlink_q   <= blink_en;
        snapBlankLz_q <= blank_lz;
      end
      seg_q       <= seg_d;
      dpN_q       <= dpN_d;
      anN_q       <= anN_d;
      frameTick_q <= firstSlot;
    end else begin
      anN_q       <= '1;
      frameTick_q <= 1'b0;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dpN_q;
  assign an_n       = anN_q;
  assign frame_tick = frameTick_q;

endmodule
